// File: rtl/tl_input_conditioner_if.sv
// Panel-side bundle: raw pins in, conditioned levels, switch pulse and mode code out.
interface tl_input_conditioner_if;
  logic       switch_raw;
  logic [4:0] s_raw;
  logic       switch;
  logic       switch_pulse;
  logic       S0;
  logic       S1;
  logic       S2;
  logic       S3;
  logic       S4;
  logic [2:0] mode;
  logic       mode_update;

  modport master (
    output switch_raw, s_raw,
    input  switch, switch_pulse, S0, S1, S2, S3, S4, mode, mode_update
  );

  modport slave (
    input  switch_raw, s_raw,
    output switch, switch_pulse, S0, S1, S2, S3, S4, mode, mode_update
  );
endinterface

// File: rtl/tl_input_conditioner.sv
// Synchronise and debounce the switch and S0..S4 panel pins; levels flip DEBOUNCE_CYCLES+2 edges
// after a stable raw change, the switch rising edge yields a one-cycle pulse that latches the mode code.
module tl_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  tl_input_conditioner_if.slave  io
);

  localparam int NCH = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // channel 0 is the switch, channels 1..5 are S0..S4
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   deb;
  logic [CNT_W-1:0] cnt [NCH];

  logic       deb_sw_d;
  logic       pulse;
  logic       sel_any;
  logic [2:0] sel_code;
  logic [2:0] mode_q;
  logic       mode_update_q;

  assign raw = {io.s_raw, io.switch_raw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign pulse = deb[0] & ~deb_sw_d;

  // highest set selector wins
  always_comb begin
    sel_any  = |deb[5:1];
    sel_code = 3'd0;
    if (deb[5])      sel_code = 3'd4;
    else if (deb[4]) sel_code = 3'd3;
    else if (deb[3]) sel_code = 3'd2;
    else if (deb[2]) sel_code = 3'd1;
    else             sel_code = 3'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_sw_d      <= 1'b0;
      mode_q        <= 3'd0;
      mode_update_q <= 1'b0;
    end else begin
      deb_sw_d      <= deb[0];
      mode_update_q <= 1'b0;
      if (pulse && sel_any) begin
        mode_q        <= sel_code;
        mode_update_q <= 1'b1;
      end
    end
  end

  assign io.switch       = deb[0];
  assign io.switch_pulse = pulse;
  assign io.S0           = deb[1];
  assign io.S1           = deb[2];
  assign io.S2           = deb[3];
  assign io.S3           = deb[4];
  assign io.S4           = deb[5];
  assign io.mode         = mode_q;
  assign io.mode_update  = mode_update_q;

endmodule

// File: tb/tb_tl_input_conditioner.sv
// Bench for tl_input_conditioner: directed panel scenarios plus randomized pin activity against a timestamp model.
module tb_tl_input_conditioner;

  localparam int D = 4;

  logic clk;
  logic reset;
  tl_input_conditioner_if tif ();

  tl_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a level flips once the synchronised pin has disagreed with it on D
  // consecutive edges since the last agreement, flip or reset (tracked as an edge timestamp).
  bit       m_deb    [6];
  int       m_anchor [6];
  bit       m_s1     [6];
  bit       m_s2     [6];
  int       ecount = 0;
  bit       m_pulse;
  bit [2:0] m_mode;
  bit       m_upd;

  always @(posedge clk or posedge reset) begin
    bit [5:0] r;
    bit       rose;
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        m_deb[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_anchor[i] = ecount;
      end
      m_pulse = 0; m_mode = 0; m_upd = 0;
    end else begin
      ecount++;
      r = {tif.s_raw, tif.switch_raw};
      m_upd = 0;
      if (m_pulse) begin
        for (int i = 1; i <= 5; i++)
          if (m_deb[i]) begin m_mode = 3'(i - 1); m_upd = 1; end
      end
      rose = 0;
      for (int i = 0; i < 6; i++) begin
        if (m_s2[i] == m_deb[i]) m_anchor[i] = ecount;
        else if (ecount - m_anchor[i] >= D) begin
          if (i == 0 && m_s2[i]) rose = 1;
          m_deb[i] = m_s2[i];
          m_anchor[i] = ecount;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = r[i];
      end
      m_pulse = rose;
    end
  end

  function automatic int s_vec();
    return {tif.S4, tif.S3, tif.S2, tif.S1, tif.S0};
  endfunction

  always @(posedge clk) begin
    #2;
    chk("switch", tif.switch, m_deb[0]);
    chk("switch_pulse", tif.switch_pulse, m_pulse);
    chk("S", s_vec(), {m_deb[5], m_deb[4], m_deb[3], m_deb[2], m_deb[1]});
    chk("mode", tif.mode, m_mode);
    chk("mode_update", tif.mode_update, m_upd);
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int all_out();
    return {tif.switch, tif.switch_pulse, tif.S4, tif.S3, tif.S2, tif.S1, tif.S0, tif.mode, tif.mode_update};
  endfunction

  initial begin
    int np, nu, ns;
    reset = 1'b1;
    tif.switch_raw = 1'b1;
    tif.s_raw = 5'b11111;

    // reset held 10 cycles with all pins high
    #50;
    chk("reset_outputs", all_out(), 0);
    #50;
    reset = 1'b0;
    step(1);
    chk("release_edge1_zero", all_out(), 0);
    step(4);
    chk("reset_edge5_switch", tif.switch, 0);
    step(1);
    chk("reset_edge6_switch", tif.switch, 1);
    chk("reset_edge6_S", s_vec(), 31);
    chk("reset_edge6_pulse", tif.switch_pulse, 1);
    step(1);
    chk("reset_edge7_pulse", tif.switch_pulse, 0);
    chk("reset_edge7_mode", tif.mode, 4);
    chk("reset_edge7_upd", tif.mode_update, 1);
    chk("model_mode_pin", m_mode, 4);
    step(1);
    chk("reset_edge8_upd", tif.mode_update, 0);

    // clean press with S0 only
    tif.switch_raw = 1'b0;
    tif.s_raw = 5'b00001;
    step(12);
    tif.switch_raw = 1'b1;
    step(5);
    chk("press_edge5_switch", tif.switch, 0);
    tif.switch_raw = 1'b0;
    step(1);
    chk("press_edge6_switch", tif.switch, 1);
    chk("press_edge6_pulse", tif.switch_pulse, 1);
    step(1);
    chk("press_mode", tif.mode, 0);
    chk("press_upd", tif.mode_update, 1);
    chk("model_upd_pin", m_upd, 1);
    np = 0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      np += tif.switch_pulse;
    end
    chk("release_edge10_switch", tif.switch, 1);
    step(1);
    chk("release_edge11_switch", tif.switch, 0);
    chk("release_no_pulse", np + tif.switch_pulse, 0);

    // 3-cycle glitch is rejected
    step(8);
    tif.switch_raw = 1'b1;
    step(3);
    tif.switch_raw = 1'b0;
    np = 0; nu = 0; ns = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      np += tif.switch_pulse; nu += tif.mode_update; ns += tif.switch;
    end
    chk("glitch_switch", ns, 0);
    chk("glitch_pulse", np, 0);
    chk("glitch_upd", nu, 0);

    // bouncing contact then stable high gives one pulse
    for (int k = 0; k < 8; k++) begin
      tif.switch_raw = ~tif.switch_raw;
      step(1);
    end
    tif.switch_raw = 1'b1;
    np = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      np += tif.switch_pulse;
    end
    chk("bounce_pulses", np, 1);
    tif.switch_raw = 1'b0;
    step(10);

    // priority: S1|S2 selects 2, then no selector keeps mode
    tif.s_raw = 5'b00110;
    step(8);
    tif.switch_raw = 1'b1;
    nu = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      nu += tif.mode_update;
    end
    chk("prio_updates", nu, 1);
    chk("prio_mode", tif.mode, 2);
    tif.switch_raw = 1'b0;
    tif.s_raw = 5'b00000;
    step(10);
    tif.switch_raw = 1'b1;
    nu = 0; np = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      nu += tif.mode_update; np += tif.switch_pulse;
    end
    chk("nosel_pulse", np, 1);
    chk("nosel_updates", nu, 0);
    chk("nosel_mode", tif.mode, 2);
    tif.switch_raw = 1'b0;
    step(10);

    // reset in the middle of a debounce count
    tif.switch_raw = 1'b1;
    step(2);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    np = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      np += tif.switch_pulse;
    end
    chk("midreset_early_pulse", np, 0);
    step(1);
    chk("midreset_edge6_pulse", tif.switch_pulse, 1);
    tif.switch_raw = 1'b0;
    step(10);

    // randomized pin activity
    for (int it = 0; it < 1500; it++) begin
      tif.switch_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) tif.s_raw = 5'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        step($urandom_range(1, 3));
        reset = 1'b0;
      end
      step($urandom_range(1, 9));
    end
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
